// File: rtl/ram_load_arbiter_pkg.sv
// Shared definitions for the CPU RAM loader: control-word bit map (same as the
// control unit uses), datapath widths, and the load arbiter state encoding.
// No ports; import with ram_load_arbiter_pkg::*.
package ram_load_arbiter_pkg;

  localparam int unsigned MarWidth   = 4;
  localparam int unsigned DataWidth  = 8;
  localparam int unsigned CtrlWidth  = 16;
  localparam int unsigned UstepWidth = 3;
  localparam int unsigned CountWidth = 5;

  // Control word bits, HLT at the MSB down to FI at the LSB.
  localparam logic [CtrlWidth-1:0] CwHlt = 16'h8000;
  localparam logic [CtrlWidth-1:0] CwMi  = 16'h4000;
  localparam logic [CtrlWidth-1:0] CwRi  = 16'h2000;
  localparam logic [CtrlWidth-1:0] CwRo  = 16'h1000;
  localparam logic [CtrlWidth-1:0] CwIo  = 16'h0800;
  localparam logic [CtrlWidth-1:0] CwIi  = 16'h0400;
  localparam logic [CtrlWidth-1:0] CwAi  = 16'h0200;
  localparam logic [CtrlWidth-1:0] CwAo  = 16'h0100;
  localparam logic [CtrlWidth-1:0] CwEo  = 16'h0080;
  localparam logic [CtrlWidth-1:0] CwSu  = 16'h0040;
  localparam logic [CtrlWidth-1:0] CwBi  = 16'h0020;
  localparam logic [CtrlWidth-1:0] CwOi  = 16'h0010;
  localparam logic [CtrlWidth-1:0] CwCe  = 16'h0008;
  localparam logic [CtrlWidth-1:0] CwCo  = 16'h0004;
  localparam logic [CtrlWidth-1:0] CwJ   = 16'h0002;
  localparam logic [CtrlWidth-1:0] CwFi  = 16'h0001;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StAddr,
    StData,
    StWait,
    StRelease,
    StErr
  } arb_state_e;

  // Saturating increment for the session byte counter.
  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
    return (v == {CountWidth{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_load_arbiter_if.sv
// Host program-loader handshake.
//   host_valid/addr/data/last : host -> arbiter, held stable until accepted
//   host_ready                : arbiter -> host, transfer on valid & ready
//   host_err                  : arbiter -> host, sticky drain-timeout error
// master = host side, slave = arbiter side.
interface ram_load_arbiter_if;
  import ram_load_arbiter_pkg::*;

  logic                 host_valid;
  logic [MarWidth-1:0]  host_addr;
  logic [DataWidth-1:0] host_data;
  logic                 host_last;
  logic                 host_ready;
  logic                 host_err;

  modport master (
    output host_valid, host_addr, host_data, host_last,
    input  host_ready, host_err
  );

  modport slave (
    input  host_valid, host_addr, host_data, host_last,
    output host_ready, host_err
  );
endinterface

// File: rtl/ram_load_arbiter_drain_timer.sv
// Counts cycles while enabled, clears when disabled, and flags on the
// Timeout-th enabled cycle so the owner can leave on that edge.
//   clk, rst  : clock, synchronous active-high reset
//   en_i      : count enable (clears counter when low)
//   expired_o : high during the Timeout-th consecutive enabled cycle onward
module ram_load_arbiter_drain_timer #(
  parameter int unsigned Timeout = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntWidth = $clog2(Timeout + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(Timeout - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // cnt_q is 0 in the first enabled cycle, so CntLast marks cycle Timeout.
  always_comb begin
    cnt_d = '0;
    if (en_i) begin
      cnt_d = (cnt_q == CntLast) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CntLast);

endmodule

// File: rtl/ram_load_arbiter.sv
// Shares CPU RAM/MAR/bus between the microcode sequencer and a host loader.
// A host request freezes the CPU at an instruction boundary, then each byte
// is written with an MI cycle (address on bus) followed by an RI cycle (data
// on bus). The last byte releases the CPU and optionally pulses a restart.
//   clk, rst       : clock, synchronous active-high reset
//   host           : host loader handshake (slave side)
//   ustep          : current microstep from the control unit
//   cpu_halted     : HLT asserted in the CPU
//   cpu_hold       : freeze CPU once ustep reaches 0
//   cpu_restart    : one-cycle pulse clearing PC and microstep
//   override_en    : ctrl_override replaces the control-unit word
//   ctrl_override  : substitute control word
//   bus_drive      : arbiter drives bus_out onto the bus
//   bus_out        : bus value
//   load_count     : bytes written this/last session, saturating
module ram_load_arbiter
  import ram_load_arbiter_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT   = 64,
  parameter bit          RESTART_ON_DONE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_load_arbiter_if.slave     host,
  input  logic [UstepWidth-1:0] ustep,
  input  logic                  cpu_halted,
  output logic                  cpu_hold,
  output logic                  cpu_restart,
  output logic                  override_en,
  output logic [CtrlWidth-1:0]  ctrl_override,
  output logic                  bus_drive,
  output logic [DataWidth-1:0]  bus_out,
  output logic [CountWidth-1:0] load_count
);

  arb_state_e            state_q, state_d;
  logic                  host_err_q, host_err_d;
  logic [CountWidth-1:0] load_count_q, load_count_d;
  logic                  drain_expired;

  ram_load_arbiter_drain_timer #(
    .Timeout (DRAIN_TIMEOUT)
  ) u_drain_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == StDrain),
    .expired_o (drain_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      host_err_q   <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      host_err_q   <= host_err_d;
      load_count_q <= load_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    host_err_d   = host_err_q;
    load_count_d = load_count_q;
    unique case (state_q)
      StIdle: begin
        if (host.host_valid && !host_err_q) begin
          state_d      = StDrain;
          load_count_d = '0;
        end
      end
      StDrain: begin
        // A halted CPU may be parked at any microstep; it is still safe to load.
        if ((ustep == '0) || cpu_halted) begin
          state_d = StAddr;
        end else if (drain_expired) begin
          state_d    = StErr;
          host_err_d = 1'b1;
        end
      end
      StAddr: state_d = StData;
      StData: begin
        load_count_d = sat_inc(load_count_q);
        state_d      = host.host_last ? StRelease : StWait;
      end
      // CPU stays frozen here until the host offers another byte.
      StWait: begin
        if (host.host_valid) begin
          state_d = StAddr;
        end
      end
      StRelease: state_d = StIdle;
      StErr:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    host.host_ready = 1'b0;
    host.host_err   = host_err_q;
    cpu_hold        = 1'b0;
    cpu_restart     = 1'b0;
    override_en     = 1'b0;
    ctrl_override   = '0;
    bus_drive       = 1'b0;
    bus_out         = '0;
    unique case (state_q)
      StDrain, StWait: cpu_hold = 1'b1;
      StAddr: begin
        cpu_hold      = 1'b1;
        override_en   = 1'b1;
        ctrl_override = CwMi;
        bus_drive     = 1'b1;
        bus_out       = {{(DataWidth - MarWidth){1'b0}}, host.host_addr};
      end
      StData: begin
        cpu_hold        = 1'b1;
        override_en     = 1'b1;
        ctrl_override   = CwRi;
        bus_drive       = 1'b1;
        bus_out         = host.host_data;
        host.host_ready = 1'b1;
      end
      StRelease: cpu_restart = RESTART_ON_DONE;
      default: ;
    endcase
  end

  assign load_count = load_count_q;

endmodule

// File: tb/tb_ram_load_arbiter.sv
module tb_ram_load_arbiter;
  import ram_load_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ustep;
  logic       cpu_halted;

  logic        cpu_hold, cpu_restart, override_en, bus_drive;
  logic [15:0] ctrl_override;
  logic [7:0]  bus_out;
  logic [4:0]  load_count;

  logic        cpu_hold2, cpu_restart2, override_en2, bus_drive2;
  logic [15:0] ctrl_override2;
  logic [7:0]  bus_out2;
  logic [4:0]  load_count2;

  int tests = 0;
  int fails = 0;
  int mi_cnt = 0, ri_cnt = 0, rs_cnt = 0, rs2_cnt = 0;

  ram_load_arbiter_if hif ();
  ram_load_arbiter_if hif2 ();

  ram_load_arbiter #(
    .DRAIN_TIMEOUT   (64),
    .RESTART_ON_DONE (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (hif),
    .ustep         (ustep),
    .cpu_halted    (cpu_halted),
    .cpu_hold      (cpu_hold),
    .cpu_restart   (cpu_restart),
    .override_en   (override_en),
    .ctrl_override (ctrl_override),
    .bus_drive     (bus_drive),
    .bus_out       (bus_out),
    .load_count    (load_count)
  );

  ram_load_arbiter #(
    .DRAIN_TIMEOUT   (64),
    .RESTART_ON_DONE (1'b0)
  ) dut2 (
    .clk           (clk),
    .rst           (rst),
    .host          (hif2),
    .ustep         (ustep),
    .cpu_halted    (cpu_halted),
    .cpu_hold      (cpu_hold2),
    .cpu_restart   (cpu_restart2),
    .override_en   (override_en2),
    .ctrl_override (ctrl_override2),
    .bus_drive     (bus_drive2),
    .bus_out       (bus_out2),
    .load_count    (load_count2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_restart) rs_cnt <= rs_cnt + 1;
      if (cpu_restart2) rs2_cnt <= rs2_cnt + 1;
      if (override_en && ctrl_override == CwMi) mi_cnt <= mi_cnt + 1;
      if (override_en && ctrl_override == CwRi) ri_cnt <= ri_cnt + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ustep = 3'd0;
    cpu_halted = 1'b0;
    hif.host_valid = 1'b0; hif.host_addr = '0; hif.host_data = '0; hif.host_last = 1'b0;
    hif2.host_valid = 1'b0; hif2.host_addr = '0; hif2.host_data = '0; hif2.host_last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++;
    if ({cpu_hold, cpu_restart, override_en, ctrl_override, bus_drive, bus_out, load_count,
         hif.host_ready, hif.host_err} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got hold=%b rs=%b ov=%b ctrl=%h bd=%b bus=%h cnt=%0d rdy=%b err=%b, want all 0",
               cpu_hold, cpu_restart, override_en, ctrl_override, bus_drive, bus_out, load_count,
               hif.host_ready, hif.host_err);
    end
    tests++;
    if ({cpu_hold2, cpu_restart2, override_en2, bus_drive2, load_count2} !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs2: got hold=%b rs=%b ov=%b bd=%b cnt=%0d, want all 0",
               cpu_hold2, cpu_restart2, override_en2, bus_drive2, load_count2);
    end
  endtask

  task automatic test_single_byte();
    ustep = 3'd0;
    cpu_halted = 1'b0;
    hif.host_valid = 1'b1; hif.host_addr = 4'h3; hif.host_data = 8'hA5; hif.host_last = 1'b1;
    tick();  // DRAIN
    tests++;
    if ({cpu_hold, override_en} !== 2'b10) begin
      fails++;
      $display("FAIL single_hold_rise: got hold=%b ov=%b, want hold=1 ov=0", cpu_hold, override_en);
    end
    tick();  // ADDR
    tests++;
    if ({override_en, bus_drive, ctrl_override, bus_out, hif.host_ready} !==
        {1'b1, 1'b1, 16'h4000, 8'h03, 1'b0}) begin
      fails++;
      $display("FAIL single_addr: got ov=%b bd=%b ctrl=%h bus=%h rdy=%b, want 1 1 4000 03 0",
               override_en, bus_drive, ctrl_override, bus_out, hif.host_ready);
    end
    tick();  // DATA
    tests++;
    if ({override_en, bus_drive, ctrl_override, bus_out, hif.host_ready} !==
        {1'b1, 1'b1, 16'h2000, 8'hA5, 1'b1}) begin
      fails++;
      $display("FAIL single_data: got ov=%b bd=%b ctrl=%h bus=%h rdy=%b, want 1 1 2000 a5 1",
               override_en, bus_drive, ctrl_override, bus_out, hif.host_ready);
    end
    tick();  // RELEASE
    hif.host_valid = 1'b0;
    tests++;
    if ({cpu_restart, cpu_hold, override_en, bus_drive, load_count} !== {4'b1000, 5'd1}) begin
      fails++;
      $display("FAIL single_release: got rs=%b hold=%b ov=%b bd=%b cnt=%0d, want rs=1 hold=0 ov=0 bd=0 cnt=1",
               cpu_restart, cpu_hold, override_en, bus_drive, load_count);
    end
    tick();  // IDLE
    tests++;
    if ({cpu_restart, cpu_hold, load_count} !== {2'b00, 5'd1}) begin
      fails++;
      $display("FAIL single_idle: got rs=%b hold=%b cnt=%0d, want rs=0 hold=0 cnt=1",
               cpu_restart, cpu_hold, load_count);
    end
  endtask

  task automatic test_drain_wait();
    int bad = 0;
    ustep = 3'd2;
    hif.host_valid = 1'b1; hif.host_addr = 4'h9; hif.host_data = 8'h3C; hif.host_last = 1'b1;
    tick();  // DRAIN
    for (int k = 0; k < 5; k++) begin
      if (cpu_hold !== 1'b1 || override_en !== 1'b0 || ctrl_override !== 16'h0) bad++;
      if (k < 4) tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL drain_hold: %0d bad cycles of 5, want hold=1 ov=0 ctrl=0 throughout", bad);
    end
    ustep = 3'd0;
    tick();  // ADDR
    tests++;
    if ({override_en, ctrl_override, bus_out} !== {1'b1, 16'h4000, 8'h09}) begin
      fails++;
      $display("FAIL drain_addr: got ov=%b ctrl=%h bus=%h, want 1 4000 09",
               override_en, ctrl_override, bus_out);
    end
    tick();  // DATA
    tests++;
    if ({ctrl_override, bus_out, hif.host_ready} !== {16'h2000, 8'h3C, 1'b1}) begin
      fails++;
      $display("FAIL drain_data: got ctrl=%h bus=%h rdy=%b, want 2000 3c 1",
               ctrl_override, bus_out, hif.host_ready);
    end
    tick();
    hif.host_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic send_byte(input logic [3:0] a, input logic [7:0] d, input logic last,
                           inout int hold_bad);
    bit got = 0;
    hif.host_valid = 1'b1; hif.host_addr = a; hif.host_data = d; hif.host_last = last;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (override_en !== bus_drive || (!override_en && ctrl_override !== 16'h0)) hold_bad++;
      if (override_en && ctrl_override == CwMi) begin
        tests++;
        if (bus_out !== {4'h0, a}) begin
          fails++;
          $display("FAIL burst_addr: got bus=%h, want %h", bus_out, {4'h0, a});
        end
      end
      if (hif.host_ready === 1'b1) begin
        got = 1;
        tests++;
        if ({ctrl_override, bus_out} !== {16'h2000, d}) begin
          fails++;
          $display("FAIL burst_data: got ctrl=%h bus=%h, want 2000 %h", ctrl_override, bus_out, d);
        end
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL burst_ready_timeout: got no ready in 20 cycles, want ready for addr %h", a);
    end
    tick();
    hif.host_valid = 1'b0;
    if (!last) begin
      for (int g = 0; g < 3; g++) begin
        if (cpu_hold !== 1'b1 || override_en !== 1'b0) hold_bad++;
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    int hold_bad = 0;
    int mi0, ri0, rs0;
    ustep = 3'd0;
    mi0 = mi_cnt; ri0 = ri_cnt; rs0 = rs_cnt;
    for (int i = 0; i < 16; i++) begin
      send_byte(4'(i), 8'(i * 7 + 1), (i == 15), hold_bad);
    end
    tick(); tick(); tick();
    tests++;
    if (hold_bad != 0) begin
      fails++;
      $display("FAIL burst_hold: got %0d bad gap/invariant cycles, want 0", hold_bad);
    end
    tests++;
    if (mi_cnt - mi0 != 16 || ri_cnt - ri0 != 16) begin
      fails++;
      $display("FAIL burst_pairs: got mi=%0d ri=%0d, want 16 16", mi_cnt - mi0, ri_cnt - ri0);
    end
    tests++;
    if (rs_cnt - rs0 != 1) begin
      fails++;
      $display("FAIL burst_restart: got %0d restart pulses, want 1", rs_cnt - rs0);
    end
    tests++;
    if (load_count !== 5'd16) begin
      fails++;
      $display("FAIL burst_count: got %0d, want 16", load_count);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    ustep = 3'd3;
    cpu_halted = 1'b0;
    hif.host_valid = 1'b1; hif.host_addr = 4'h1; hif.host_data = 8'h01; hif.host_last = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      tick();
      if (override_en !== 1'b0 || bus_drive !== 1'b0) bad++;
      if (i == 64) begin
        tests++;
        if ({cpu_hold, hif.host_err} !== 2'b10) begin
          fails++;
          $display("FAIL timeout_drain64: got hold=%b err=%b, want hold=1 err=0",
                   cpu_hold, hif.host_err);
        end
      end
    end
    tests++;
    if ({hif.host_err, cpu_hold, bus_drive} !== 3'b100) begin
      fails++;
      $display("FAIL timeout_err: got err=%b hold=%b bd=%b, want err=1 hold=0 bd=0",
               hif.host_err, cpu_hold, bus_drive);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_hold !== 1'b0 || override_en !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0 || hif.host_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_ignore: got %0d bad cycles err=%b, want 0 bad err=1", bad, hif.host_err);
    end
    hif.host_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (hif.host_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: got err=%b after rst, want 0", hif.host_err);
    end
    ustep = 3'd0;
    tick();
  endtask

  task automatic test_reset_in_data();
    ustep = 3'd0;
    hif.host_valid = 1'b1; hif.host_addr = 4'h5; hif.host_data = 8'h77; hif.host_last = 1'b0;
    tick(); tick(); tick();  // DRAIN, ADDR, DATA
    tests++;
    if (hif.host_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstdata_reach: got rdy=%b, want 1 in DATA", hif.host_ready);
    end
    rst = 1'b1;
    hif.host_valid = 1'b0;
    tick();
    tests++;
    if ({cpu_hold, cpu_restart, override_en, ctrl_override, bus_drive, bus_out, load_count,
         hif.host_ready, hif.host_err} !== 35'd0) begin
      fails++;
      $display("FAIL rstdata_outputs: got hold=%b rs=%b ov=%b ctrl=%h bd=%b bus=%h cnt=%0d rdy=%b err=%b, want all 0",
               cpu_hold, cpu_restart, override_en, ctrl_override, bus_drive, bus_out, load_count,
               hif.host_ready, hif.host_err);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({cpu_restart, cpu_hold} !== 2'b00) begin
      fails++;
      $display("FAIL rstdata_after: got rs=%b hold=%b, want 0 0", cpu_restart, cpu_hold);
    end
  endtask

  task automatic test_no_restart();
    int seen = 0;
    ustep = 3'd2;
    cpu_halted = 1'b1;
    hif2.host_valid = 1'b1; hif2.host_addr = 4'hA; hif2.host_data = 8'h5A; hif2.host_last = 1'b1;
    tick();  // DRAIN
    if (cpu_restart2 === 1'b1) seen++;
    tick();  // ADDR, granted despite ustep=2
    tests++;
    if ({override_en2, ctrl_override2, bus_out2} !== {1'b1, 16'h4000, 8'h0A}) begin
      fails++;
      $display("FAIL norst_addr: got ov=%b ctrl=%h bus=%h, want 1 4000 0a",
               override_en2, ctrl_override2, bus_out2);
    end
    tick();  // DATA
    tests++;
    if ({ctrl_override2, bus_out2, hif2.host_ready} !== {16'h2000, 8'h5A, 1'b1}) begin
      fails++;
      $display("FAIL norst_data: got ctrl=%h bus=%h rdy=%b, want 2000 5a 1",
               ctrl_override2, bus_out2, hif2.host_ready);
    end
    tick();  // RELEASE
    hif2.host_valid = 1'b0;
    if (cpu_restart2 === 1'b1) seen++;
    tests++;
    if ({cpu_hold2, load_count2} !== {1'b0, 5'd1}) begin
      fails++;
      $display("FAIL norst_release: got hold=%b cnt=%0d, want hold=0 cnt=1", cpu_hold2, load_count2);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_restart2 === 1'b1) seen++;
    end
    tests++;
    if (seen != 0 || rs2_cnt != 0) begin
      fails++;
      $display("FAIL norst_pulse: got %0d/%0d restart pulses, want 0", seen, rs2_cnt);
    end
    cpu_halted = 1'b0;
    ustep = 3'd0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_drain_wait();
    test_back_to_back();
    test_timeout();
    test_reset_in_data();
    test_no_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_load_arbiter.md
Name: ram_load_arbiter

Overview:
- Shares the CPU's RAM, MAR and bus between the microcode sequencer and an external host program loader.
- On a host request it freezes the CPU at an instruction boundary and takes bus ownership.
- For each byte it issues its own control words: MI with the address on the bus, then RI with the data on the bus.
- When the host marks the last byte, it returns the bus to the CPU and optionally pulses a CPU restart.

Parameters:
- DRAIN_TIMEOUT, 64: max cycles in DRAIN waiting for microstep 0 before error.
- RESTART_ON_DONE, 1: pulse cpu_restart after a completed session when 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- host_valid  in  1  host offers a byte; addr, data and last held stable until accepted.
- host_addr  in  4  RAM address.
- host_data  in  8  RAM data.
- host_last  in  1  final byte of session.
- host_ready  out  1  byte accepted (transfer when valid & ready).
- host_err  out  1  sticky drain-timeout error.
- ustep  in  3  current microstep from the control unit.
- cpu_halted  in  1  HLT asserted in the CPU.
- cpu_hold  out  1  freeze CPU; control unit must stop advancing once ustep==0.
- cpu_restart  out  1  one-cycle pulse: clear PC and microstep.
- override_en  out  1  ctrl_override replaces the control-unit word.
- ctrl_override  out  16  control word; same bit map as control unit (HLT=15 … FI=0).
- bus_drive  out  1  arbiter drives bus_out onto the 8-bit bus.
- bus_out  out  8  bus value.
- load_count  out  5  bytes written in the current/last session, saturating at 31.

Behaviour:
- Reset:
  - All outputs 0, state IDLE, host_err cleared, load_count 0.
  - Reset mid-session abandons the session immediately; no restart pulse.
- States: IDLE, DRAIN, ADDR, DATA, WAIT, RELEASE, ERR.
- IDLE:
  - host_valid → DRAIN; cpu_hold=1 from the next cycle; load_count cleared.
  - host_valid ignored while host_err=1.
- DRAIN:
  - cpu_hold=1; override_en=0.
  - (ustep==0 or cpu_halted) → ADDR.
  - Cycle counter reaching DRAIN_TIMEOUT → ERR.
- ADDR (1 cycle):
  - override_en=1, ctrl_override=MI (bit 14), bus_drive=1, bus_out={4'b0, host_addr}.
  - Always → DATA.
- DATA (1 cycle):
  - override_en=1, ctrl_override=RI (bit 13), bus_drive=1, bus_out=host_data.
  - host_ready=1 (only state where ready is high).
  - load_count increments (saturating).
  - host_last → RELEASE, else WAIT.
- WAIT:
  - cpu_hold=1, override_en=0, bus_drive=0.
  - host_valid → ADDR; no second drain needed since the CPU is still frozen.
- RELEASE (1 cycle):
  - cpu_hold=0, override_en=0.
  - cpu_restart=RESTART_ON_DONE.
  - → IDLE.
- ERR (1 cycle):
  - host_err=1 (sticky until rst), cpu_hold=0.
  - → IDLE.
- Write latency: 2 cycles per byte from ADDR entry; first byte ADDR entry is 1 cycle after the drain condition is sampled.
- bus_drive=1 only in ADDR/DATA, and override_en equals bus_drive, so the CPU never drives the bus concurrently.
- ctrl_override=0 whenever override_en=0.
- cpu_halted=1 with the CPU stuck at ustep≠0 still grants; loading into a halted CPU is legal.
- host_valid dropping in WAIT keeps the hold indefinitely. This is intentional: the session ends only on host_last or rst.

Decomposition:
- Shared package cpu_pkg:
  - 16 control-word bit constants (HLT…FI); the control unit is migrated to use them.
  - Arbiter state enum.
  - MAR and data widths (4, 8).
- Sub-module drain_timer: counts while enabled, clears on disable, flags at DRAIN_TIMEOUT.

Test Plan:
- Idle CPU at ustep=0, single byte addr=4'h3 data=8'hA5 last=1:
  - cpu_hold rises one cycle after valid; ADDR gives MI, bus=8'h03; DATA gives RI, bus=8'hA5, host_ready=1.
  - RELEASE gives cpu_restart=1 for one cycle; load_count=1.
- Request arriving at ustep=2:
  - Stays in DRAIN with override_en=0 until ustep returns to 0, then ADDR the next cycle.
- 16-byte burst with addrs 0..15 and host_valid gapped 3 cycles between bytes:
  - cpu_hold stays high throughout; exactly 16 MI/RI pairs; load_count=16; one restart pulse.
- ustep forced to 3 and cpu_halted=0 for 64 cycles:
  - ERR, host_err=1, cpu_hold=0, no bus drive.
  - Subsequent host_valid is ignored until rst.
- rst asserted while in DATA:
  - Next cycle all outputs 0, state IDLE, no cpu_restart, host_err=0.
- RESTART_ON_DONE=0 with cpu_halted=1 at ustep=2:
  - Grant is immediate; write completes; cpu_restart never pulses.
